// File: rtl/ex_pkg.sv
// Shared definitions for the parametrised execute stage: opcodes, flag bit
// positions and the multi-cycle sequencing states.
package ex_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MOV = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_XOR = 5'b00110;
    localparam logic [4:0] OP_NOT = 5'b00111;
    localparam logic [4:0] OP_ADI = 5'b01000;
    localparam logic [4:0] OP_SBI = 5'b01001;
    localparam logic [4:0] OP_MVI = 5'b01010;
    localparam logic [4:0] OP_DIV = 5'b01011;
    localparam logic [4:0] OP_ANI = 5'b01100;
    localparam logic [4:0] OP_ORI = 5'b01101;
    localparam logic [4:0] OP_XRI = 5'b01110;
    localparam logic [4:0] OP_NTI = 5'b01111;
    localparam logic [4:0] OP_RET = 5'b10000;
    localparam logic [4:0] OP_HLT = 5'b10001;
    localparam logic [4:0] OP_LD  = 5'b10100;
    localparam logic [4:0] OP_ST  = 5'b10101;
    localparam logic [4:0] OP_IN  = 5'b10110;
    localparam logic [4:0] OP_OUT = 5'b10111;
    localparam logic [4:0] OP_JMP = 5'b11000;
    localparam logic [4:0] OP_LS  = 5'b11001;
    localparam logic [4:0] OP_RS  = 5'b11010;
    localparam logic [4:0] OP_RSA = 5'b11011;
    localparam logic [4:0] OP_JC  = 5'b11100;
    localparam logic [4:0] OP_JNC = 5'b11101;
    localparam logic [4:0] OP_JZ  = 5'b11110;
    localparam logic [4:0] OP_JNZ = 5'b11111;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_P = 3;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/iterative_muldiv.sv
// Bit-serial unsigned multiplier (shift-add) and restoring divider sharing one
// WIDTH+1-bit adder. done is high during the final iteration cycle; lo/hi are final after it.
module iterative_muldiv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned SUM_W = WIDTH + 2;

    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             mode_div;
    logic [WIDTH-1:0] m;

    logic [WIDTH:0]   add_a_c;
    logic [WIDTH:0]   add_b_c;
    logic             add_cin_c;
    logic [SUM_W-1:0] add_sum_c;
    logic [WIDTH:0]   rem_shift_c;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_shift_c = {hi, lo[WIDTH-1]};

    // Shared adder: accumulate multiplicand, or trial-subtract the divisor.
    always_comb begin
        add_a_c   = {1'b0, hi};
        add_b_c   = '0;
        add_cin_c = 1'b0;
        if (mode_div) begin
            add_a_c   = rem_shift_c;
            add_b_c   = ~{1'b0, m};
            add_cin_c = 1'b1;
        end else if (lo[0]) begin
            add_b_c = {1'b0, m};
        end
    end

    assign add_sum_c = SUM_W'(add_a_c) + SUM_W'(add_b_c) + SUM_W'(add_cin_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            running     <= 1'b0;
            mode_div    <= 1'b0;
            m           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lo          <= '0;
            hi          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mode_div <= is_div;
                m        <= b;
                cnt      <= '0;
                busy     <= 1'b1;
                // Division by zero skips iteration entirely.
                if (is_div && (b == '0)) begin
                    running     <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                    hi          <= a;
                    lo          <= '1;
                end else begin
                    running     <= 1'b1;
                    div_by_zero <= 1'b0;
                    hi          <= '0;
                    lo          <= a;
                end
            end else begin
                if (done) begin
                    busy <= 1'b0;
                end
                if (running) begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 2)) begin
                        done <= 1'b1;
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        running <= 1'b0;
                    end
                    if (mode_div) begin
                        if (add_sum_c[WIDTH+1]) begin
                            hi <= add_sum_c[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= rem_shift_c[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi <= add_sum_c[WIDTH:1];
                        lo <= {add_sum_c[0], lo[WIDTH-1:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ex_stage_muldiv.sv
// Execute stage: single-cycle ALU, iterative MUL/DIV sequencing, pipeline
// registers toward memory and the persistent flag register.
module ex_stage_muldiv
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op_dec,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       RW_dec,
    input  logic             mem_en_dec,
    input  logic             mem_rw_dec,
    input  logic             mem_mux_sel_dec,
    output logic             out_valid,
    output logic [WIDTH-1:0] ans_ex,
    output logic [WIDTH-1:0] hi_ex,
    output logic [WIDTH-1:0] B_Bypass,
    output logic [WIDTH-1:0] data_out,
    output logic [3:0]       flag_ex,
    output logic             mem_en_ex,
    output logic             mem_rw_ex,
    output logic             mem_mux_sel_ex,
    output logic [4:0]       RW_ex
);

    localparam int unsigned SUM_W = WIDTH + 1;

    state_t state, state_next;

    logic             accept_c;
    logic             is_mul_c;
    logic             is_div_c;
    logic             md_start_c;

    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic             md_dbz;

    logic [4:0]       pend_rw;
    logic             pend_mem_en;
    logic             pend_mem_rw;
    logic             pend_mux_sel;
    logic             pend_div;

    logic [SUM_W-1:0] add_sum_c;
    logic [SUM_W-1:0] sub_sum_c;
    logic [WIDTH-1:0] ls_c;
    logic [WIDTH-1:0] rs_c;
    logic [WIDTH-1:0] rsa_c;

    logic [WIDTH-1:0] alu_res_c;
    logic             alu_cf_c;
    logic             alu_vf_c;
    logic             ld_flags_c;
    logic             clr_flags_c;
    logic             ld_ans_c;
    logic             illegal_c;
    logic [3:0]       alu_flags_c;
    logic [3:0]       md_flags_c;

    assign accept_c   = in_valid & in_ready;
    assign is_mul_c   = MULDIV_EN && (op_dec == OP_MUL);
    assign is_div_c   = MULDIV_EN && (op_dec == OP_DIV);
    assign md_start_c = accept_c & (is_mul_c | is_div_c);

    iterative_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .reset       (reset),
        .start       (md_start_c),
        .is_div      (is_div_c),
        .a           (A),
        .b           (B),
        .busy        (md_busy),
        .done        (md_done),
        .lo          (md_lo),
        .hi          (md_hi),
        .div_by_zero (md_dbz)
    );

    assign add_sum_c = {1'b0, A} + {1'b0, B};
    assign sub_sum_c = {1'b0, A} + {1'b0, ~B} + SUM_W'(1'b1);
    assign ls_c      = A << B;
    assign rs_c      = A >> B;
    assign rsa_c     = $unsigned($signed(A) >>> B);

    // Single-cycle result, flag sources and register-update policy per opcode.
    always_comb begin
        alu_res_c   = '0;
        alu_cf_c    = 1'b0;
        alu_vf_c    = 1'b0;
        ld_flags_c  = 1'b0;
        clr_flags_c = 1'b0;
        ld_ans_c    = 1'b0;
        illegal_c   = 1'b0;
        case (op_dec)
            OP_ADD, OP_ADI: begin
                alu_res_c  = add_sum_c[WIDTH-1:0];
                alu_cf_c   = add_sum_c[WIDTH];
                alu_vf_c   = add_sum_c[WIDTH] ^ (A[WIDTH-1] ^ B[WIDTH-1] ^ add_sum_c[WIDTH-1]);
                ld_flags_c = 1'b1;
                ld_ans_c   = 1'b1;
            end
            OP_SUB, OP_SBI: begin
                alu_res_c  = sub_sum_c[WIDTH-1:0];
                alu_cf_c   = sub_sum_c[WIDTH];
                alu_vf_c   = sub_sum_c[WIDTH] ^ (A[WIDTH-1] ^ ~B[WIDTH-1] ^ sub_sum_c[WIDTH-1]);
                ld_flags_c = 1'b1;
                ld_ans_c   = 1'b1;
            end
            OP_MOV, OP_MVI: begin alu_res_c = B;      ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_AND, OP_ANI: begin alu_res_c = A & B;  ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_OR,  OP_ORI: begin alu_res_c = A | B;  ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_XOR, OP_XRI: begin alu_res_c = A ^ B;  ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_NOT, OP_NTI: begin alu_res_c = ~B;     ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_LS:          begin alu_res_c = ls_c;   ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_RS:          begin alu_res_c = rs_c;   ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_RSA:         begin alu_res_c = rsa_c;  ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_IN:          begin alu_res_c = data_in; ld_flags_c = 1'b1; ld_ans_c = 1'b1; end
            OP_LD, OP_ST:   begin alu_res_c = A;      ld_ans_c = 1'b1; end
            OP_RET, OP_HLT: clr_flags_c = 1'b1;
            OP_OUT, OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: ;
            OP_MUL, OP_DIV: illegal_c = !MULDIV_EN;
            default:        illegal_c = 1'b1;
        endcase
    end

    always_comb begin
        alu_flags_c         = '0;
        alu_flags_c[FLAG_C] = alu_cf_c;
        alu_flags_c[FLAG_Z] = (alu_res_c == '0);
        alu_flags_c[FLAG_V] = alu_vf_c;
        alu_flags_c[FLAG_P] = ^alu_res_c;
    end

    // MUL overflow means a non-zero high half; DIV flags only a zero divisor.
    always_comb begin
        md_flags_c         = '0;
        md_flags_c[FLAG_P] = ^md_lo;
        if (pend_div) begin
            md_flags_c[FLAG_Z] = (md_lo == '0);
            md_flags_c[FLAG_V] = md_dbz;
        end else begin
            md_flags_c[FLAG_Z] = (md_lo == '0) && (md_hi == '0);
            md_flags_c[FLAG_C] = (md_hi != '0);
            md_flags_c[FLAG_V] = (md_hi != '0);
        end
    end

    // Sequencer next state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_c && is_mul_c) begin
                    state_next = ST_MUL_RUN;
                end else if (accept_c && is_div_c) begin
                    state_next = ST_DIV_RUN;
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (md_done) begin
                    state_next = ST_DONE;
                end else if (!md_busy) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == ST_IDLE);
        end
    end

    // Pipeline and flag registers; bubbles clear only the valid/side-effect fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            ans_ex         <= '0;
            hi_ex          <= '0;
            B_Bypass       <= '0;
            data_out       <= '0;
            flag_ex        <= '0;
            mem_en_ex      <= 1'b0;
            mem_rw_ex      <= 1'b0;
            mem_mux_sel_ex <= 1'b0;
            RW_ex          <= '0;
            pend_rw        <= '0;
            pend_mem_en    <= 1'b0;
            pend_mem_rw    <= 1'b0;
            pend_mux_sel   <= 1'b0;
            pend_div       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            mem_en_ex <= 1'b0;
            RW_ex     <= '0;
            if (state == ST_DONE) begin
                out_valid      <= 1'b1;
                ans_ex         <= md_lo;
                hi_ex          <= md_hi;
                flag_ex        <= md_flags_c;
                RW_ex          <= pend_rw;
                mem_en_ex      <= pend_mem_en;
                mem_rw_ex      <= pend_mem_rw;
                mem_mux_sel_ex <= pend_mux_sel;
            end else if (md_start_c) begin
                B_Bypass     <= B;
                pend_rw      <= RW_dec;
                pend_mem_en  <= mem_en_dec;
                pend_mem_rw  <= mem_rw_dec;
                pend_mux_sel <= mem_mux_sel_dec;
                pend_div     <= is_div_c;
            end else if (accept_c) begin
                out_valid      <= 1'b1;
                B_Bypass       <= B;
                RW_ex          <= RW_dec;
                mem_en_ex      <= mem_en_dec;
                mem_rw_ex      <= mem_rw_dec;
                mem_mux_sel_ex <= mem_mux_sel_dec;
                hi_ex          <= '0;
                if (illegal_c) begin
                    ans_ex <= '0;
                end else if (ld_ans_c) begin
                    ans_ex <= alu_res_c;
                end
                if (ld_flags_c) begin
                    flag_ex <= alu_flags_c;
                end else if (clr_flags_c) begin
                    flag_ex <= '0;
                end
                if (op_dec == OP_OUT) begin
                    data_out <= A;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed bench for ex_stage_muldiv at WIDTH=8: ALU flags, flag policy,
// MUL/DIV latency and results, reset abort, shifts and OUT.
module tb_ex_stage_muldiv;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] op_dec = 5'b0;
    logic [7:0] A = 8'h0;
    logic [7:0] B = 8'h0;
    logic [7:0] data_in = 8'h0;
    logic [4:0] RW_dec = 5'd0;
    logic       mem_en_dec = 1'b0;
    logic       mem_rw_dec = 1'b0;
    logic       mem_mux_sel_dec = 1'b0;
    logic       out_valid;
    logic [7:0] ans_ex;
    logic [7:0] hi_ex;
    logic [7:0] B_Bypass;
    logic [7:0] data_out;
    logic [3:0] flag_ex;
    logic       mem_en_ex;
    logic       mem_rw_ex;
    logic       mem_mux_sel_ex;
    logic [4:0] RW_ex;

    int vectors = 0;
    int miscompares = 0;
    bit saw_valid;

    ex_stage_muldiv #(.WIDTH(8), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_dec(op_dec), .A(A), .B(B), .data_in(data_in), .RW_dec(RW_dec),
        .mem_en_dec(mem_en_dec), .mem_rw_dec(mem_rw_dec), .mem_mux_sel_dec(mem_mux_sel_dec),
        .out_valid(out_valid), .ans_ex(ans_ex), .hi_ex(hi_ex), .B_Bypass(B_Bypass),
        .data_out(data_out), .flag_ex(flag_ex), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
        .mem_mux_sel_ex(mem_mux_sel_ex), .RW_ex(RW_ex)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [4:0] rw, input logic men);
        in_valid   = 1'b1;
        op_dec     = op;
        A          = a;
        B          = b;
        RW_dec     = rw;
        mem_en_dec = men;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_state", 32'({in_ready, out_valid, ans_ex, hi_ex, flag_ex, data_out, RW_ex}),
            32'({1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 5'd0}));

        // ADD 7F+01: C=0 Z=0 V=1 P=1
        issue(5'b00000, 8'h7F, 8'h01, 5'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("add_ans", 32'(ans_ex), 32'h80);
        chk("add_flags", 32'(flag_ex), 32'hC);
        chk("add_valid_rw", 32'({out_valid, RW_ex, hi_ex, B_Bypass}), 32'({1'b1, 5'd3, 8'h00, 8'h01}));
        tick();
        chk("bubble", 32'({out_valid, RW_ex, mem_en_ex, ans_ex, flag_ex}), 32'({1'b0, 5'd0, 1'b0, 8'h80, 4'hC}));

        // SUB 5-5 then JMP
        issue(5'b00001, 8'h05, 8'h05, 5'd4, 1'b0);
        tick();
        chk("sub_ans_flags", 32'({ans_ex, flag_ex}), 32'({8'h00, 4'h3}));
        issue(5'b11000, 8'h44, 8'h12, 5'd5, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("jmp_hold", 32'({out_valid, ans_ex, flag_ex, B_Bypass}), 32'({1'b1, 8'h00, 4'h3, 8'h12}));

        // MUL 10*10 with an ADD waiting behind it
        issue(5'b00011, 8'h10, 8'h10, 5'd7, 1'b1);
        tick();
        issue(5'b00000, 8'h01, 8'h01, 5'd9, 1'b0);
        chk("mul_stall0", 32'({in_ready, out_valid}), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("mul_stall%0d", i), 32'({in_ready, out_valid}), 32'h0);
        end
        tick();
        chk("mul_result", 32'({out_valid, ans_ex, hi_ex, flag_ex}), 32'({1'b1, 8'h00, 8'h01, 4'h5}));
        chk("mul_ctrl", 32'({in_ready, RW_ex, mem_en_ex, B_Bypass}), 32'({1'b1, 5'd7, 1'b1, 8'h10}));
        tick();
        in_valid = 1'b0;
        chk("add_after_mul", 32'({out_valid, RW_ex, ans_ex, hi_ex, flag_ex}),
            32'({1'b1, 5'd9, 8'h02, 8'h00, 4'h8}));

        // DIV 100/7
        issue(5'b01011, 8'd100, 8'd7, 5'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        chk("div_pre", 32'(out_valid), 32'h0);
        tick();
        chk("div_result", 32'({out_valid, ans_ex, hi_ex, flag_ex}), 32'({1'b1, 8'h0E, 8'h02, 4'h8}));

        // DIV by zero: latency 2
        issue(5'b01011, 8'h33, 8'h00, 5'd6, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("dbz_pre", 32'(out_valid), 32'h0);
        tick();
        chk("dbz_result", 32'({out_valid, ans_ex, hi_ex, flag_ex, RW_ex}), 32'({1'b1, 8'hFF, 8'h33, 4'h4, 5'd6}));

        // Reset four cycles into a MUL
        issue(5'b00011, 8'hFF, 8'hFF, 5'd1, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_state", 32'({in_ready, out_valid, ans_ex, hi_ex, flag_ex, RW_ex, mem_en_ex}),
            32'({1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 5'd0, 1'b0}));
        chk("abort_regs", 32'({B_Bypass, data_out, mem_rw_ex, mem_mux_sel_ex}), 32'h0);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_valid", 32'({saw_valid, in_ready}), 32'({1'b0, 1'b1}));

        // RSA, illegal, LS, OUT, RET, LD
        issue(5'b11011, 8'h90, 8'd3, 5'd1, 1'b0);
        tick();
        chk("rsa", 32'({ans_ex, flag_ex}), 32'({8'hF2, 4'h8}));
        issue(5'b10010, 8'h11, 8'h22, 5'd2, 1'b0);
        tick();
        chk("illegal", 32'({out_valid, ans_ex, hi_ex, flag_ex}), 32'({1'b1, 8'h00, 8'h00, 4'h8}));
        issue(5'b11001, 8'h5A, 8'd9, 5'd3, 1'b0);
        tick();
        chk("ls_wide", 32'({ans_ex, flag_ex}), 32'({8'h00, 4'h2}));
        issue(5'b10111, 8'hA5, 8'h00, 5'd0, 1'b0);
        tick();
        chk("out", 32'({data_out, flag_ex, ans_ex}), 32'({8'hA5, 4'h2, 8'h00}));
        issue(5'b10000, 8'h77, 8'h00, 5'd0, 1'b0);
        tick();
        chk("ret", 32'({flag_ex, ans_ex, data_out}), 32'({4'h0, 8'h00, 8'hA5}));
        issue(5'b10100, 8'h3C, 8'h01, 5'd8, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("ld", 32'({ans_ex, flag_ex, mem_en_ex, RW_ex}), 32'({8'h3C, 4'h0, 1'b1, 5'd8}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
